prn_nh_gen: RTL



---
 rtl/prn_nh_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prn_nh_gen.sv
`default_nettype none
// ============================================================================
// Module      : prn_nh_gen
// Description : Per-channel GPS C/A Gold-code and NH secondary-code generator.
//               A code-NCO overflow (code_en) advances the chip. The block keeps
//               the chip index within the 1023-chip epoch and the NH bit index.
//               Its complete state can be saved on the *_o ports and restored
//               through the *_i ports for time-multiplexed correlation.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   code_en        in   advance one chip (code-NCO overflow)
//   state_load_en  in   load g1/g2/code_cnt/nh_cnt from the *_i ports
//   g1_i, g2_i     in   LFSR load values (10 bits each)
//   code_cnt_i     in   chip index load value (10 bits)
//   nh_cnt_i       in   NH index load value (5 bits)
//   g2_init_i      in   G2 state at chip 0 (selects the PRN)
//   nh_pattern_i   in   NH pattern, bit k is NH chip k
//   nh_length_i    in   NH length, 0 disables NH
//   g1_o, g2_o, code_cnt_o, nh_cnt_o  out  current state for state save
//   prn_code       out  current C/A chip
//   nh_code        out  current NH chip (0 when NH disabled)
//   code_epoch     out  one-cycle pulse after a code wrap
//   nh_epoch       out  one-cycle pulse after an NH wrap
// ============================================================================
module prn_nh_gen #(
    parameter int CODE_LEN = 1023,
    parameter int NH_W     = 25
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            code_en,
    input  logic            state_load_en,
    input  logic [9:0]      g1_i,
    input  logic [9:0]      g2_i,
    input  logic [9:0]      code_cnt_i,
    input  logic [4:0]      nh_cnt_i,
    input  logic [9:0]      g2_init_i,
    input  logic [NH_W-1:0] nh_pattern_i,
    input  logic [4:0]      nh_length_i,
    output logic [9:0]      g1_o,
    output logic [9:0]      g2_o,
    output logic [9:0]      code_cnt_o,
    output logic [4:0]      nh_cnt_o,
    output logic            prn_code,
    output logic            nh_code,
    output logic            code_epoch,
    output logic            nh_epoch
);

    localparam logic [9:0] LAST_CHIP = 10'(CODE_LEN - 1);
    localparam logic [9:0] LFSR_SEED = 10'h3FF;

    logic [9:0] g1_q, g1_d;
    logic [9:0] g2_q, g2_d;
    logic [9:0] code_cnt_q, code_cnt_d;
    logic [4:0] nh_cnt_q, nh_cnt_d;
    logic       code_epoch_q, code_epoch_d;
    logic       nh_epoch_q, nh_epoch_d;

    logic       w_fb1;
    logic       w_fb2;
    logic       w_code_wrap;
    logic       w_nh_wrap;
    logic       w_nh_bit;

    assign w_fb1 = g1_q[2] ^ g1_q[9];
    assign w_fb2 = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];

    // ">=" rather than "==" so an out-of-range loaded index still wraps on
    // the next step instead of counting through the unused code space.
    assign w_code_wrap = (code_cnt_q >= LAST_CHIP);
    assign w_nh_wrap   = (nh_cnt_q >= (nh_length_i - 5'd1));

    // NH bit select; indices beyond the pattern width read as 0.
    always_comb begin
        w_nh_bit = 1'b0;
        for (int k = 0; k < NH_W; k++) begin
            if (nh_cnt_q == 5'(k)) begin
                w_nh_bit = nh_pattern_i[k];
            end
        end
    end

    always_comb begin
        g1_d         = g1_q;
        g2_d         = g2_q;
        code_cnt_d   = code_cnt_q;
        nh_cnt_d     = nh_cnt_q;
        code_epoch_d = 1'b0;
        nh_epoch_d   = 1'b0;

        if (state_load_en) begin
            // A load overrides a coincident advance; the controller re-issues it.
            g1_d       = g1_i;
            g2_d       = g2_i;
            code_cnt_d = code_cnt_i;
            nh_cnt_d   = nh_cnt_i;
        end else if (code_en) begin
            if (w_code_wrap) begin
                code_cnt_d   = 10'd0;
                g1_d         = LFSR_SEED;
                g2_d         = g2_init_i;
                code_epoch_d = 1'b1;
                if (nh_length_i == 5'd0) begin
                    nh_cnt_d = 5'd0;
                end else if (w_nh_wrap) begin
                    nh_cnt_d   = 5'd0;
                    nh_epoch_d = 1'b1;
                end else begin
                    nh_cnt_d = nh_cnt_q + 5'd1;
                end
            end else begin
                g1_d       = {g1_q[8:0], w_fb1};
                g2_d       = {g2_q[8:0], w_fb2};
                code_cnt_d = code_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_q         <= LFSR_SEED;
            g2_q         <= LFSR_SEED;
            code_cnt_q   <= 10'd0;
            nh_cnt_q     <= 5'd0;
            code_epoch_q <= 1'b0;
            nh_epoch_q   <= 1'b0;
        end else begin
            g1_q         <= g1_d;
            g2_q         <= g2_d;
            code_cnt_q   <= code_cnt_d;
            nh_cnt_q     <= nh_cnt_d;
            code_epoch_q <= code_epoch_d;
            nh_epoch_q   <= nh_epoch_d;
        end
    end

    assign g1_o       = g1_q;
    assign g2_o       = g2_q;
    assign code_cnt_o = code_cnt_q;
    assign nh_cnt_o   = nh_cnt_q;
    assign prn_code   = g1_q[9] ^ g2_q[9];
    assign nh_code    = (nh_length_i != 5'd0) & w_nh_bit;
    assign code_epoch = code_epoch_q;
    assign nh_epoch   = nh_epoch_q;

endmodule
`default_nettype wire
